// File: rtl/am25ls191.sv
// rtl/am25ls191.sv - presettable synchronous binary up/down counter with max/min flag and ripple carry
module am25ls191 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic [WIDTH-1:0] in,
  input  logic             load_,
  input  logic             ent_,
  input  logic             ud,
  output logic [WIDTH-1:0] q,
  output logic             mxmn,
  output logic             rco_
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      q <= '0;
    end else if (!load_) begin
      q <= in;
    end else if (!ent_) begin
      q <= ud ? (q - ONE) : (q + ONE);
    end
  end

  assign mxmn = ud ? (q == '0) : (q == '1);

  // Carry is gated by the low clock phase so it can drive the next stage's clk directly.
  assign rco_ = ~(mxmn & ~ent_ & ~clk);

endmodule

// File: tb/tb_am25ls191.sv
// tb/tb_am25ls191.sv - directed self-checking bench for am25ls191
module tb_am25ls191;

  logic       clk;
  logic       rst_;
  logic [3:0] in;
  logic       load_;
  logic       ent_;
  logic       ud;
  logic [3:0] q;
  logic       mxmn;
  logic       rco_;

  int total = 0;
  int bad   = 0;

  am25ls191 #(.WIDTH(4)) dut (
    .clk  (clk),
    .rst_ (rst_),
    .in   (in),
    .load_(load_),
    .ent_ (ent_),
    .ud   (ud),
    .q    (q),
    .mxmn (mxmn),
    .rco_ (rco_)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] eq, input logic em, input logic er);
    chk({tag, ".q"}, q, eq);
    chk({tag, ".mxmn"}, {3'b000, mxmn}, {3'b000, em});
    chk({tag, ".rco_"}, {3'b000, rco_}, {3'b000, er});
  endtask

  // Advance past the next falling edge; inputs change and outputs are checked here.
  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst_  = 1'b0;
    in    = 4'b0000;
    load_ = 1'b1;
    ent_  = 1'b0;
    ud    = 1'b0;

    // reset state, then direction change alters flags without a clock
    #2;
    chk_all("reset_up", 4'b0000, 1'b0, 1'b1);
    ud = 1'b1;
    #1;
    chk_all("reset_down", 4'b0000, 1'b1, 1'b0);

    // load 1101, then count up through the wrap
    load_ = 1'b0;
    in    = 4'b1101;
    #1;
    rst_ = 1'b1;
    tick();
    chk_all("load_1101", 4'b1101, 1'b0, 1'b1);
    load_ = 1'b1;
    ent_  = 1'b0;
    ud    = 1'b0;
    in    = 4'bxxxx;
    tick(); chk_all("up_1110", 4'b1110, 1'b0, 1'b1);
    tick(); chk_all("up_1111", 4'b1111, 1'b1, 1'b0);
    tick(); chk_all("up_wrap", 4'b0000, 1'b0, 1'b1);
    tick(); chk_all("up_0001", 4'b0001, 1'b0, 1'b1);
    tick(); chk_all("up_0010", 4'b0010, 1'b0, 1'b1);

    // inhibit
    ent_ = 1'b1;
    tick(); chk_all("hold_1", 4'b0010, 1'b0, 1'b1);
    tick(); chk_all("hold_2", 4'b0010, 1'b0, 1'b1);

    // count down through the wrap
    ud   = 1'b1;
    ent_ = 1'b0;
    tick(); chk_all("dn_0001", 4'b0001, 1'b0, 1'b1);
    tick(); chk_all("dn_0000", 4'b0000, 1'b1, 1'b0);
    tick(); chk_all("dn_wrap", 4'b1111, 1'b0, 1'b1);
    tick(); chk_all("dn_1110", 4'b1110, 1'b0, 1'b1);
    tick(); chk_all("dn_1101", 4'b1101, 1'b0, 1'b1);

    // flag gating at q=1111, ud=0; load overrides ent_ so q stays put
    load_ = 1'b0;
    in    = 4'b1111;
    ud    = 1'b0;
    ent_  = 1'b1;
    tick(); chk_all("gate_ent_off", 4'b1111, 1'b1, 1'b1);
    ent_ = 1'b0;
    @(posedge clk);
    #1;
    chk_all("gate_clk_high", 4'b1111, 1'b1, 1'b1);
    tick(); chk_all("gate_clk_low", 4'b1111, 1'b1, 1'b0);

    // asynchronous reset between edges
    in = 4'b1010;
    tick(); chk_all("load_1010", 4'b1010, 1'b0, 1'b1);
    load_ = 1'b1;
    ent_  = 1'b1;
    #1;
    rst_ = 1'b0;
    #1;
    chk_all("async_rst", 4'b0000, 1'b0, 1'b1);
    rst_ = 1'b1;
    ent_ = 1'b0;
    tick(); chk_all("resume_0001", 4'b0001, 1'b0, 1'b1);
    tick(); chk_all("resume_0010", 4'b0010, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
